// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
//   EX-stage ALU with a valid/ready handshake. FUNCTION/ALUOP are decoded into a
//   3-bit operation at acceptance. ADD/SUB/AND/OR/SLT/NOP finish in one cycle.
//   MUL (unsigned shift-add) and DIV (unsigned restoring) run one bit per cycle
//   and hold READY low until they finish; their latency is WIDTH cycles.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset (wins over an accept in the same cycle)
//   VALID_IN   request; it is sampled together with the operands only when READY=1
//   READY      high while idle (decoded from the state register only)
//   FUNCTION   R-type funct field
//   ALUOP      main-control ALU op class
//   A, B       operands (A = rs/dividend, B = rt/divisor)
//   VALID_OUT  one-cycle pulse that qualifies RESULT and the flags
//   RESULT     result (MUL: low WIDTH bits of the product; DIV: quotient)
//   REMAINDER  DIV remainder; 0 for all other ops
//   ZERO       RESULT == 0
//   DIV_ZERO   DIV with B == 0
//   ILLEGAL    FUNCTION/ALUOP could not be decoded
//   OP         decoded op of the last accepted request
// -----------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VALID_IN,
    output logic             READY,
    input  logic [5:0]       FUNCTION,
    input  logic [2:0]       ALUOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             VALID_OUT,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             ZERO,
    output logic             DIV_ZERO,
    output logic             ILLEGAL,
    output logic [2:0]       OP
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10
    } state_t;

    // Returns {illegal, op}. An undecodable request becomes NOP with illegal set.
    function automatic logic [3:0] decode_op(input logic [5:0] funct, input logic [2:0] aluop);
        logic [3:0] d;
        d = {1'b1, OP_NOP};
        case (aluop)
            3'b010: begin
                case (funct)
                    6'b100000: d = {1'b0, OP_ADD};
                    6'b100010: d = {1'b0, OP_SUB};
                    6'b100100: d = {1'b0, OP_AND};
                    6'b100101: d = {1'b0, OP_OR};
                    6'b101010: d = {1'b0, OP_SLT};
                    6'b011000: d = {1'b0, OP_MUL};
                    6'b011010: d = {1'b0, OP_DIV};
                    6'b000000: d = {1'b0, OP_NOP};
                    default:   d = {1'b1, OP_NOP};
                endcase
            end
            3'b011:  d = {1'b0, OP_ADD};
            3'b100:  d = {1'b0, OP_SUB};
            3'b111:  d = {1'b0, OP_AND};
            3'b101:  d = {1'b0, OP_OR};
            3'b001:  d = {1'b0, OP_SLT};
            default: d = {1'b1, OP_NOP};
        endcase
        return d;
    endfunction

    // Result of the single-cycle ops; MUL/DIV/NOP yield 0 here.
    function automatic logic [WIDTH-1:0] alu_result(input logic [2:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = ZERO_W;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = ZERO_W;
        endcase
        return r;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_dz;

    logic             r_valid_out;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_zero;
    logic             r_div_zero;
    logic             r_illegal;
    logic [2:0]       r_op;

    logic             w_idle;
    logic             w_accept;
    logic [3:0]       w_dec;
    logic [2:0]       w_dec_op;
    logic             w_dec_ill;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_last;

    logic [WIDTH-1:0] w_src_acc;
    logic [WIDTH-1:0] w_src_mcand;
    logic [WIDTH-1:0] w_src_mplier;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mcand_nxt;
    logic [WIDTH-1:0] w_mplier_nxt;
    logic [WIDTH-1:0] w_src_rem;
    logic [WIDTH-1:0] w_src_quo;
    logic [WIDTH-1:0] w_src_dvs;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = VALID_IN & w_idle;
    assign w_dec       = decode_op(FUNCTION, ALUOP);
    assign w_dec_op    = w_dec[2:0];
    assign w_dec_ill   = w_dec[3];
    assign w_sc_result = alu_result(w_dec_op, A, B);
    // The iteration that completes an operation runs while the counter reads 1.
    assign w_last      = (r_cnt == CNT_W'(1));

    // One shift-add and one restoring-divide step. The first step runs on the
    // accept edge straight from the operands, so WIDTH steps fit in WIDTH cycles.
    always_comb begin
        w_src_acc    = w_idle ? ZERO_W : r_acc;
        w_src_mcand  = w_idle ? A : r_mcand;
        w_src_mplier = w_idle ? B : r_mplier;
        w_acc_nxt    = w_src_acc + (w_src_mplier[0] ? w_src_mcand : ZERO_W);
        w_mcand_nxt  = w_src_mcand << 1;
        w_mplier_nxt = w_src_mplier >> 1;

        w_src_rem    = w_idle ? ZERO_W : r_rem;
        w_src_quo    = w_idle ? A : r_quo;
        w_src_dvs    = w_idle ? B : r_divisor;
        // r_quo shifts dividend bits out at the top and quotient bits in at the bottom.
        w_trial      = {w_src_rem, w_src_quo[WIDTH-1]};
        w_qbit       = (w_trial >= {1'b0, w_src_dvs});
        // When the step subtracts, the difference is below the divisor and fits WIDTH bits.
        if (w_qbit) begin
            w_rem_nxt = w_trial[WIDTH-1:0] - w_src_dvs;
        end else begin
            w_rem_nxt = w_trial[WIDTH-1:0];
        end
        w_quo_nxt    = {w_src_quo[WIDTH-2:0], w_qbit};
    end

    // Next-state logic for the sequencing FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_dec_op == OP_MUL)) begin
                    w_state_nxt = S_MUL;
                end else if (w_accept && (w_dec_op == OP_DIV)) begin
                    w_state_nxt = S_DIV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: iteration registers, counter and the registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt       <= {CNT_W{1'b0}};
            r_acc       <= ZERO_W;
            r_mcand     <= ZERO_W;
            r_mplier    <= ZERO_W;
            r_rem       <= ZERO_W;
            r_quo       <= ZERO_W;
            r_divisor   <= ZERO_W;
            r_dz        <= 1'b0;
            r_valid_out <= 1'b0;
            r_result    <= ZERO_W;
            r_remainder <= ZERO_W;
            r_zero      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
            r_op        <= OP_NOP;
        end else begin
            // Flags and VALID_OUT are pulses; RESULT/REMAINDER/OP hold.
            r_valid_out <= 1'b0;
            r_zero      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= w_dec_op;
                        if ((w_dec_op == OP_MUL) || (w_dec_op == OP_DIV)) begin
                            r_cnt     <= CNT_W'(WIDTH - 1);
                            r_acc     <= w_acc_nxt;
                            r_mcand   <= w_mcand_nxt;
                            r_mplier  <= w_mplier_nxt;
                            r_rem     <= w_rem_nxt;
                            r_quo     <= w_quo_nxt;
                            r_divisor <= B;
                            r_dz      <= (B == ZERO_W);
                        end else begin
                            r_valid_out <= 1'b1;
                            r_result    <= w_sc_result;
                            r_remainder <= ZERO_W;
                            r_zero      <= (w_sc_result == ZERO_W);
                            r_illegal   <= w_dec_ill;
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_MUL: begin
                    r_cnt    <= r_cnt - CNT_W'(1);
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= w_mcand_nxt;
                    r_mplier <= w_mplier_nxt;
                    if (w_last) begin
                        r_valid_out <= 1'b1;
                        r_result    <= w_acc_nxt;
                        r_remainder <= ZERO_W;
                        r_zero      <= (w_acc_nxt == ZERO_W);
                    end else begin
                        r_valid_out <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (w_last) begin
                        // A zero divisor makes every step subtract nothing, so the
                        // quotient comes out all ones and the remainder equals A.
                        r_valid_out <= 1'b1;
                        r_result    <= w_quo_nxt;
                        r_remainder <= w_rem_nxt;
                        r_zero      <= (w_quo_nxt == ZERO_W);
                        r_div_zero  <= r_dz;
                    end else begin
                        r_valid_out <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign READY     = w_idle;
    assign VALID_OUT = r_valid_out;
    assign RESULT    = r_result;
    assign REMAINDER = r_remainder;
    assign ZERO      = r_zero;
    assign DIV_ZERO  = r_div_zero;
    assign ILLEGAL   = r_illegal;
    assign OP        = r_op;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: one 32-bit and one 8-bit instance.
module tb_alu_seq_unit;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        logic        z;
        logic        dz;
        logic        ill;
        logic [2:0]  op;
        int          lat;
    } out_t;

    typedef struct {
        bit          is8;
        logic [5:0]  f;
        logic [2:0]  al;
        logic [31:0] a;
        logic [31:0] b;
        out_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v32, rdy32, vo32, z32, dz32, il32;
    logic [5:0]  f32;
    logic [2:0]  al32, op32;
    logic [31:0] a32, b32, res32, rem32;

    logic        v8, rdy8, vo8, z8, dz8, il8;
    logic [5:0]  f8;
    logic [2:0]  al8, op8;
    logic [7:0]  a8, b8, res8, rem8;

    int total = 0;
    int bad   = 0;

    alu_seq_unit #(.WIDTH(32)) u_dut32 (
        .CLK(clk), .RST(rst), .VALID_IN(v32), .READY(rdy32), .FUNCTION(f32), .ALUOP(al32),
        .A(a32), .B(b32), .VALID_OUT(vo32), .RESULT(res32), .REMAINDER(rem32), .ZERO(z32),
        .DIV_ZERO(dz32), .ILLEGAL(il32), .OP(op32)
    );

    alu_seq_unit #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst), .VALID_IN(v8), .READY(rdy8), .FUNCTION(f8), .ALUOP(al8),
        .A(a8), .B(b8), .VALID_OUT(vo8), .RESULT(res8), .REMAINDER(rem8), .ZERO(z8),
        .DIV_ZERO(dz8), .ILLEGAL(il8), .OP(op8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference: op semantics straight from the ISA rules, using native arithmetic.
    function automatic out_t model(input bit is8, input logic [5:0] f, input logic [2:0] al,
                                   input logic [31:0] a, input logic [31:0] b);
        out_t o;
        logic [31:0] mask, am, bm;
        longint sa, sb;
        longint unsigned p;
        mask = is8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
        am = a & mask;
        bm = b & mask;
        o.res = 32'd0; o.rem = 32'd0; o.dz = 1'b0; o.ill = 1'b0; o.lat = 1; o.op = 3'b111;
        case (al)
            3'b010: begin
                case (f)
                    6'b100000: o.op = 3'b000;
                    6'b100010: o.op = 3'b001;
                    6'b100100: o.op = 3'b010;
                    6'b100101: o.op = 3'b011;
                    6'b101010: o.op = 3'b100;
                    6'b011000: o.op = 3'b101;
                    6'b011010: o.op = 3'b110;
                    6'b000000: o.op = 3'b111;
                    default:   o.ill = 1'b1;
                endcase
            end
            3'b011: o.op = 3'b000;
            3'b100: o.op = 3'b001;
            3'b111: o.op = 3'b010;
            3'b101: o.op = 3'b011;
            3'b001: o.op = 3'b100;
            default: o.ill = 1'b1;
        endcase
        sa = is8 ? longint'($signed(am[7:0])) : longint'($signed(am));
        sb = is8 ? longint'($signed(bm[7:0])) : longint'($signed(bm));
        case (o.op)
            3'b000: o.res = (am + bm) & mask;
            3'b001: o.res = (am - bm) & mask;
            3'b010: o.res = am & bm;
            3'b011: o.res = am | bm;
            3'b100: o.res = (sa < sb) ? 32'd1 : 32'd0;
            3'b101: begin
                p = longint'(am) * longint'(bm);
                o.res = p[31:0] & mask;
                o.lat = is8 ? 8 : 32;
            end
            3'b110: begin
                o.lat = is8 ? 8 : 32;
                if (bm == 32'd0) begin
                    o.res = mask; o.rem = am; o.dz = 1'b1;
                end else begin
                    o.res = am / bm; o.rem = am % bm;
                end
            end
            default: o.res = 32'd0;
        endcase
        o.z = (o.res == 32'd0);
        return o;
    endfunction

    // Issue one request, wait for its VALID_OUT, report outputs, latency and READY-low cycles.
    task automatic run_op(input bit is8, input logic [5:0] f, input logic [2:0] al,
                          input logic [31:0] a, input logic [31:0] b,
                          output out_t got, output int low_cnt, output logic rdy_done);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(is8 ? rdy8 : rdy32) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) timeout_fail("ready_wait");
        if (is8) begin
            v8 = 1'b1; f8 = f; al8 = al; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            v32 = 1'b1; f32 = f; al32 = al; a32 = a; b32 = b;
        end
        @(posedge clk); #1;
        v8 = 1'b0; v32 = 1'b0;
        got.lat = 1;
        low_cnt = 0;
        while (!(is8 ? vo8 : vo32) && got.lat < 200) begin
            if (!(is8 ? rdy8 : rdy32)) low_cnt++;
            @(posedge clk); #1;
            got.lat++;
        end
        if (got.lat >= 200) timeout_fail("valid_out_wait");
        if (is8) begin
            got.res = {24'd0, res8}; got.rem = {24'd0, rem8}; got.z = z8; got.dz = dz8;
            got.ill = il8; got.op = op8; rdy_done = rdy8;
        end else begin
            got.res = res32; got.rem = rem32; got.z = z32; got.dz = dz32;
            got.ill = il32; got.op = op32; rdy_done = rdy32;
        end
    endtask

    task automatic compare(input string tag, input out_t g, input out_t e,
                           input int low_cnt, input logic rdy_done);
        check($sformatf("%s.res", tag), g.res, e.res);
        check($sformatf("%s.rem", tag), g.rem, e.rem);
        check($sformatf("%s.zero", tag), {31'd0, g.z}, {31'd0, e.z});
        check($sformatf("%s.div_zero", tag), {31'd0, g.dz}, {31'd0, e.dz});
        check($sformatf("%s.illegal", tag), {31'd0, g.ill}, {31'd0, e.ill});
        check($sformatf("%s.op", tag), {29'd0, g.op}, {29'd0, e.op});
        check($sformatf("%s.latency", tag), g.lat, e.lat);
        check($sformatf("%s.ready_low", tag), low_cnt, e.lat - 1);
        check($sformatf("%s.ready_at_done", tag), {31'd0, rdy_done}, 32'd1);
    endtask

    vec_t tbl[$];

    function automatic void add_vec(input bit is8, input logic [5:0] f, input logic [2:0] al,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] res, input logic [31:0] rem,
                                    input logic z, input logic dz, input logic ill,
                                    input logic [2:0] op, input int lat);
        vec_t v;
        v.is8 = is8; v.f = f; v.al = al; v.a = a; v.b = b;
        v.e.res = res; v.e.rem = rem; v.e.z = z; v.e.dz = dz; v.e.ill = ill;
        v.e.op = op; v.e.lat = lat;
        tbl.push_back(v);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t        g, e;
        int          low, pulses;
        logic        rdyd;
        logic [5:0]  legal_f[8];
        legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b101010, 6'b011000, 6'b011010, 6'b000000};

        //            is8   funct      aluop   a              b             res            rem    z     dz    ill   op      lat
        add_vec(1'b0, 6'b100000, 3'b010, 32'd7,         32'd5,         32'd12,        32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1);
        add_vec(1'b0, 6'b000000, 3'b100, 32'd3,         32'd5,         32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1);
        add_vec(1'b0, 6'b101010, 3'b010, 32'hFFFF_FFFF, 32'd1,         32'd1,         32'd0, 1'b0, 1'b0, 1'b0, 3'b100, 1);
        add_vec(1'b0, 6'b000000, 3'b111, 32'h0000_00F0, 32'h0000_000F, 32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1);
        add_vec(1'b1, 6'b011000, 3'b010, 32'd13,        32'd11,        32'h8F,        32'd0, 1'b0, 1'b0, 1'b0, 3'b101, 8);
        add_vec(1'b1, 6'b011010, 3'b010, 32'd200,       32'd7,         32'd28,        32'd4, 1'b0, 1'b0, 1'b0, 3'b110, 8);
        add_vec(1'b1, 6'b011010, 3'b010, 32'd9,         32'd0,         32'hFF,        32'd9, 1'b0, 1'b1, 1'b0, 3'b110, 8);
        add_vec(1'b0, 6'b111111, 3'b010, 32'd4,         32'd4,         32'd0,         32'd0, 1'b1, 1'b0, 1'b1, 3'b111, 1);
        add_vec(1'b0, 6'b000000, 3'b101, 32'h0000_00A0, 32'h0000_0005, 32'h0000_00A5, 32'd0, 1'b0, 1'b0, 1'b0, 3'b011, 1);
        add_vec(1'b0, 6'b000000, 3'b001, 32'd5,         32'd3,         32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 3'b100, 1);
        add_vec(1'b0, 6'b000000, 3'b010, 32'd5,         32'd6,         32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 3'b111, 1);
        add_vec(1'b0, 6'b100000, 3'b000, 32'd5,         32'd6,         32'd0,         32'd0, 1'b1, 1'b0, 1'b1, 3'b111, 1);
        add_vec(1'b0, 6'b100000, 3'b110, 32'd5,         32'd6,         32'd0,         32'd0, 1'b1, 1'b0, 1'b1, 3'b111, 1);
        add_vec(1'b0, 6'b011000, 3'b010, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 32'd0, 1'b0, 1'b0, 1'b0, 3'b101, 32);
        add_vec(1'b0, 6'b011010, 3'b010, 32'd100,       32'd7,         32'd14,        32'd2, 1'b0, 1'b0, 1'b0, 3'b110, 32);
        add_vec(1'b1, 6'b101010, 3'b010, 32'h80,        32'h7F,        32'd1,         32'd0, 1'b0, 1'b0, 1'b0, 3'b100, 1);
        add_vec(1'b1, 6'b100010, 3'b010, 32'd0,         32'd1,         32'hFF,        32'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1);
        add_vec(1'b0, 6'b000000, 3'b011, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1);

        // Reset held two cycles with requests pending.
        rst = 1'b1;
        v32 = 1'b1; f32 = 6'b100000; al32 = 3'b010; a32 = 32'd7; b32 = 32'd5;
        v8  = 1'b1; f8  = 6'b100000; al8  = 3'b010; a8  = 8'd7;  b8  = 8'd5;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_valid_out32", {31'd0, vo32}, 32'd0);
            check("rst_valid_out8", {31'd0, vo8}, 32'd0);
        end
        rst = 1'b0; v32 = 1'b0; v8 = 1'b0;
        check("rst_ready32", {31'd0, rdy32}, 32'd1);
        check("rst_result32", res32, 32'd0);
        check("rst_rem32", rem32, 32'd0);
        check("rst_op32", {29'd0, op32}, 32'd7);
        check("rst_flags32", {29'd0, z32, dz32, il32}, 32'd0);
        check("rst_ready8", {31'd0, rdy8}, 32'd1);
        check("rst_op8", {29'd0, op8}, 32'd7);
        @(posedge clk); #1;
        check("post_rst_idle_valid32", {31'd0, vo32}, 32'd0);

        // Table-driven vectors.
        foreach (tbl[i]) begin
            run_op(tbl[i].is8, tbl[i].f, tbl[i].al, tbl[i].a, tbl[i].b, g, low, rdyd);
            compare($sformatf("vec%0d", i), g, tbl[i].e, low, rdyd);
        end

        // Back-to-back single-cycle ops, one accept per cycle.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            v32 = 1'b1; f32 = tbl[i].f; al32 = tbl[i].al; a32 = tbl[i].a; b32 = tbl[i].b;
            @(posedge clk); #1;
            check($sformatf("b2b%0d.valid", i), {31'd0, vo32}, 32'd1);
            check($sformatf("b2b%0d.res", i), res32, tbl[i].e.res);
            check($sformatf("b2b%0d.zero", i), {31'd0, z32}, {31'd0, tbl[i].e.z});
        end
        v32 = 1'b0;
        @(posedge clk); #1;
        check("b2b.valid_cleared", {31'd0, vo32}, 32'd0);

        // MUL 13x11 on 8 bits, then an ADD accepted in the completion cycle.
        run_op(1'b1, 6'b011000, 3'b010, 32'd13, 32'd11, g, low, rdyd);
        check("mul8.latency", g.lat, 8);
        check("mul8.ready_low", low, 7);
        check("mul8.res", g.res, 32'h8F);
        v8 = 1'b1; f8 = 6'b100000; al8 = 3'b010; a8 = 8'd20; b8 = 8'd30;
        @(posedge clk); #1;
        v8 = 1'b0;
        check("mul8_then_add.valid", {31'd0, vo8}, 32'd1);
        check("mul8_then_add.res", {24'd0, res8}, 32'd50);
        check("mul8_then_add.op", {29'd0, op8}, 32'd0);
        @(posedge clk); #1;
        check("mul8_then_add.valid_cleared", {31'd0, vo8}, 32'd0);
        check("mul8_then_add.res_hold", {24'd0, res8}, 32'd50);

        // RST three cycles into a 32-bit DIV aborts it.
        @(negedge clk);
        v32 = 1'b1; f32 = 6'b011010; al32 = 3'b010; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk); #1;
        v32 = 1'b0;
        pulses = 0;
        check("abort.busy", {31'd0, rdy32}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (vo32) pulses++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (vo32) pulses++;
        check("abort.ready", {31'd0, rdy32}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (vo32) pulses++;
        end
        check("abort.no_valid_out", pulses, 32'd0);
        run_op(1'b0, 6'b100000, 3'b010, 32'd1, 32'd1, g, low, rdyd);
        check("abort.add_res", g.res, 32'd2);
        check("abort.add_latency", g.lat, 1);

        // Randomized requests against the reference model.
        for (int i = 0; i < 120; i++) begin
            bit          is8;
            logic [5:0]  f;
            logic [2:0]  al;
            logic [31:0] a, b;
            is8 = (i % 2) == 1;
            al  = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
            if (al == 3'b010 && $urandom_range(0, 9) != 0) f = legal_f[$urandom_range(0, 7)];
            else f = 6'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            e = model(is8, f, al, a, b);
            run_op(is8, f, al, a, b, g, low, rdyd);
            compare($sformatf("rnd%0d", i), g, e, low, rdyd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
